pixel_burst_engine: RTL and testbench

Parametrised SRAM burst engine between the edge-detector datapath and the external pixel SRAM. On a `start` request it reads a programmable run of RGB words, converts each to a greyscale pixel into an output window, then writes a programmable run of greyscale pixels back, replicated into R, G and B. It generalises the fixed 20-pixel read-then-write controller with:
- parametrised burst depth, pixel width and SRAM access time;
- a start/busy/done handshake;
- zero-length phase skipping and an error path.

---
 rtl/pixel_pkg.sv | 31 +++
 rtl/flex_counter.sv | 38 +++
 rtl/pixel_burst_engine.sv | 219 +++++++++++++++++++++
 tb/tb_pixel_burst_engine.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_pkg.sv
// pixel_pkg
// Shared types and helpers for the pixel SRAM burst engine.
//   burst_state_t : controller state encoding (IDLE, READ, WRITE, DONE)
//   grey_of()     : RGB -> greyscale conversion. Components are passed
//                   zero-extended to GREY_MAX_BITS so one function serves
//                   every PIX_BITS up to GREY_MAX_BITS; the caller truncates
//                   the result to its own pixel width.
package pixel_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } burst_state_t;

    localparam int GREY_MAX_BITS = 16;

    // rgb = {R, G, B}, each GREY_MAX_BITS wide.
    // grey ~= 0.332 * (R+G+B) using four shifted copies of the sum.
    function automatic logic [GREY_MAX_BITS+1:0] grey_of(
        input logic [3*GREY_MAX_BITS-1:0] rgb
    );
        logic [GREY_MAX_BITS+1:0] s;
        s = {2'b00, rgb[3*GREY_MAX_BITS-1:2*GREY_MAX_BITS]}
          + {2'b00, rgb[2*GREY_MAX_BITS-1:GREY_MAX_BITS]}
          + {2'b00, rgb[GREY_MAX_BITS-1:0]};
        return (s >> 2) + (s >> 4) + (s >> 6) + (s >> 8);
    endfunction

endpackage

// File: rtl/flex_counter.sv
// flex_counter
// Wrapping up-counter used as a wait-state timer.
//   clk, n_rst     : clock, asynchronous active-low reset
//   clear          : synchronous clear to 0 (wins over count_enable)
//   count_enable   : advance by one per cycle
//   rollover_val   : last value before wrapping back to 0
//   rollover_flag  : high in the cycle the counter sits at rollover_val
//                    while enabled (i.e. the last cycle of a period)
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic                    rollover_flag
);

    logic [NUM_CNT_BITS-1:0] count_q;

    always_ff @(posedge clk, negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (count_enable) begin
            if (count_q == rollover_val) begin
                count_q <= '0;
            end else begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign rollover_flag = count_enable && (count_q == rollover_val);

endmodule

// File: rtl/pixel_burst_engine.sv
// pixel_burst_engine
// On start, reads rd_count RGB words from SRAM starting at rd_base, stores
// the greyscale of each in rd_pixels, then writes wr_count greyscale pixels
// (replicated into R, G and B) starting at wr_base. Every SRAM word access
// is held for WAIT_CYCLES cycles.
// Ports:
//   clk, n_rst            : clock, asynchronous active-low reset
//   start                 : request, accepted only in IDLE
//   rd_base, wr_base      : first read / write address
//   rd_count, wr_count    : words to read / write (> MAX_BURST -> err)
//   wr_pixels             : pixels to write, sampled live during WRITE
//   rd_pixels             : greyscale results of the read phase
//   busy, done, err       : status; done is a one-cycle pulse, err valid with done
//   sram_addr/wdata/rdata : SRAM bus
//   sram_re, sram_we      : SRAM strobes, mutually exclusive
// All outputs are registered.
module pixel_burst_engine
    import pixel_pkg::*;
#(
    parameter  int ADDR_BITS   = 16,
    parameter  int PIX_BITS    = 8,
    parameter  int MAX_BURST   = 20,
    parameter  int WAIT_CYCLES = 9,
    localparam int CNT_BITS    = $clog2(MAX_BURST + 1)
) (
    input  logic                               clk,
    input  logic                               n_rst,
    input  logic                               start,
    input  logic [ADDR_BITS-1:0]               rd_base,
    input  logic [ADDR_BITS-1:0]               wr_base,
    input  logic [CNT_BITS-1:0]                rd_count,
    input  logic [CNT_BITS-1:0]                wr_count,
    input  logic [MAX_BURST-1:0][PIX_BITS-1:0] wr_pixels,
    output logic [MAX_BURST-1:0][PIX_BITS-1:0] rd_pixels,
    output logic                               busy,
    output logic                               done,
    output logic                               err,
    output logic [ADDR_BITS-1:0]               sram_addr,
    output logic [3*PIX_BITS-1:0]              sram_wdata,
    input  logic [3*PIX_BITS-1:0]              sram_rdata,
    output logic                               sram_re,
    output logic                               sram_we
);

    localparam int WAIT_BITS = $clog2(WAIT_CYCLES + 1);

    burst_state_t                        state_q, state_d;
    logic [ADDR_BITS-1:0]                wr_base_q;
    logic [CNT_BITS-1:0]                 rd_cnt_q, wr_cnt_q;
    logic [CNT_BITS-1:0]                 word_q, word_d;
    logic [ADDR_BITS-1:0]                addr_q, addr_d;
    logic [3*PIX_BITS-1:0]               wdata_q, wdata_d;
    logic                                re_q, re_d, we_q, we_d;
    logic                                busy_q, busy_d, done_q, done_d;
    logic                                err_q, err_d;
    logic [MAX_BURST-1:0][PIX_BITS-1:0]  rd_pix_q;
    logic                                tick;
    logic                                in_phase;
    logic [PIX_BITS-1:0]                 wr_pix_sel;
    logic [PIX_BITS-1:0]                 grey_now;

    assign in_phase = (state_q == READ) || (state_q == WRITE);

    // Wait-state timer; restarted whenever the state changes so each phase
    // starts its first word with a full window.
    flex_counter #(
        .NUM_CNT_BITS (WAIT_BITS)
    ) u_wait_timer (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (state_d != state_q),
        .count_enable  (in_phase),
        .rollover_val  (WAIT_BITS'(WAIT_CYCLES - 1)),
        .rollover_flag (tick)
    );

    // Requires PIX_BITS <= GREY_MAX_BITS; sum fits in PIX_BITS+2 bits and the
    // ~0.332 weighting keeps the result inside PIX_BITS.
    assign grey_now = PIX_BITS'(grey_of({
        GREY_MAX_BITS'(sram_rdata[3*PIX_BITS-1:2*PIX_BITS]),
        GREY_MAX_BITS'(sram_rdata[2*PIX_BITS-1:PIX_BITS]),
        GREY_MAX_BITS'(sram_rdata[PIX_BITS-1:0])}));

    // Pixel for the word that will be on the bus next cycle.
    always_comb begin
        wr_pix_sel = '0;
        for (int k = 0; k < MAX_BURST; k++) begin
            if (word_d == CNT_BITS'(k)) begin
                wr_pix_sel = wr_pixels[k];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        addr_d  = addr_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    word_d = '0;
                    err_d  = 1'b0;
                    if (rd_count > CNT_BITS'(MAX_BURST) || wr_count > CNT_BITS'(MAX_BURST)) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else if (rd_count != '0) begin
                        state_d = READ;
                        addr_d  = rd_base;
                    end else if (wr_count != '0) begin
                        state_d = WRITE;
                        addr_d  = wr_base;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            READ: begin
                if (tick) begin
                    if (word_q == rd_cnt_q - CNT_BITS'(1)) begin
                        word_d = '0;
                        if (wr_cnt_q != '0) begin
                            state_d = WRITE;
                            addr_d  = wr_base_q;
                        end else begin
                            state_d = DONE;
                        end
                    end else begin
                        word_d = word_q + CNT_BITS'(1);
                        addr_d = addr_q + ADDR_BITS'(1);
                    end
                end
            end
            WRITE: begin
                if (tick) begin
                    if (word_q == wr_cnt_q - CNT_BITS'(1)) begin
                        word_d  = '0;
                        state_d = DONE;
                    end else begin
                        word_d = word_q + CNT_BITS'(1);
                        addr_d = addr_q + ADDR_BITS'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered from the next state so strobes fall in the
        // same cycle the state leaves a phase.
        re_d    = (state_d == READ);
        we_d    = (state_d == WRITE);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
        wdata_d = wdata_q;
        if (state_d == WRITE) begin
            wdata_d = {3{wr_pix_sel}};
        end
    end

    always_ff @(posedge clk, negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            wr_base_q <= '0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            word_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            re_q      <= 1'b0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            re_q    <= re_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (state_q == IDLE && start) begin
                wr_base_q <= wr_base;
                rd_cnt_q  <= rd_count;
                wr_cnt_q  <= wr_count;
            end
        end
    end

    // Capture at the edge that ends the current read word's window.
    always_ff @(posedge clk, negedge n_rst) begin
        if (!n_rst) begin
            rd_pix_q <= '0;
        end else if (state_q == READ && tick) begin
            for (int k = 0; k < MAX_BURST; k++) begin
                if (word_q == CNT_BITS'(k)) begin
                    rd_pix_q[k] <= grey_now;
                end
            end
        end
    end

    assign rd_pixels  = rd_pix_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;
    assign sram_re    = re_q;
    assign sram_we    = we_q;

endmodule

// File: tb/tb_pixel_burst_engine.sv
// tb_pixel_burst_engine
// Directed and randomized transactions against a cycle-indexed model of the
// burst engine: for access cycle i the expected bus activity is derived
// directly from i, the counts and WAIT_CYCLES.
module tb_pixel_burst_engine;

    localparam int AB = 16;
    localparam int PB = 8;
    localparam int MB = 20;
    localparam int WC = 9;
    localparam int CB = $clog2(MB + 1);

    logic                  clk = 1'b0;
    logic                  n_rst;
    logic                  start;
    logic [AB-1:0]         rd_base, wr_base;
    logic [CB-1:0]         rd_count, wr_count;
    logic [MB-1:0][PB-1:0] wr_pixels;
    logic [MB-1:0][PB-1:0] rd_pixels;
    logic                  busy, done, err;
    logic [AB-1:0]         sram_addr;
    logic [3*PB-1:0]       sram_wdata, sram_rdata;
    logic                  sram_re, sram_we;

    int total = 0;
    int bad   = 0;

    logic [PB-1:0]   model_rd   [MB];
    logic [3*PB-1:0] rdata_tab  [MB];

    always #5 clk = ~clk;

    pixel_burst_engine #(
        .ADDR_BITS   (AB),
        .PIX_BITS    (PB),
        .MAX_BURST   (MB),
        .WAIT_CYCLES (WC)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .rd_base    (rd_base),
        .wr_base    (wr_base),
        .rd_count   (rd_count),
        .wr_count   (wr_count),
        .wr_pixels  (wr_pixels),
        .rd_pixels  (rd_pixels),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .sram_re    (sram_re),
        .sram_we    (sram_we)
    );

    function automatic logic [PB-1:0] ref_grey(input logic [3*PB-1:0] rgb);
        int s;
        s = int'(rgb[23:16]) + int'(rgb[15:8]) + int'(rgb[7:0]);
        return PB'(s / 4 + s / 16 + s / 64 + s / 256);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_re", 64'(sram_re), 64'd0);
        chk("rst_we", 64'(sram_we), 64'd0);
        chk("rst_addr", 64'(sram_addr), 64'd0);
        chk("rst_wdata", 64'(sram_wdata), 64'd0);
        chk("rst_rdpix", 64'(rd_pixels == '0), 64'd1);
    endtask

    // ignore_at: access index at which a second start is pulsed (with zero
    // counts); abort_at: access index at which reset is asserted.
    task automatic run_txn(input logic [AB-1:0] rb, input logic [AB-1:0] wb,
                           input int rc, input int wc,
                           input int ignore_at, input int abort_at);
        int            n_acc;
        int            w;
        logic          err_exp;
        logic [AB-1:0] a;
        err_exp = (rc > MB) || (wc > MB);
        n_acc   = err_exp ? 0 : (rc + wc) * WC;
        @(negedge clk);
        rd_base  = rb;
        wr_base  = wb;
        rd_count = CB'(rc);
        wr_count = CB'(wc);
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < n_acc; i++) begin
            start = 1'b0;
            if (i < rc * WC) begin
                w = i / WC;
                a = rb + AB'(w);
                sram_rdata = rdata_tab[w];
                chk("rd_re", 64'(sram_re), 64'd1);
                chk("rd_we", 64'(sram_we), 64'd0);
                chk("rd_addr", 64'(sram_addr), 64'(a));
            end else begin
                w = (i - rc * WC) / WC;
                a = wb + AB'(w);
                chk("wr_we", 64'(sram_we), 64'd1);
                chk("wr_re", 64'(sram_re), 64'd0);
                chk("wr_addr", 64'(sram_addr), 64'(a));
                chk("wr_data", 64'(sram_wdata), 64'({3{wr_pixels[w]}}));
            end
            chk("acc_busy", 64'(busy), 64'd1);
            chk("acc_done", 64'(done), 64'd0);
            if (i == ignore_at) begin
                rd_count = '0;
                wr_count = '0;
                start    = 1'b1;
            end
            if (i == abort_at) begin
                chk("pre_rst_pix0", 64'(rd_pixels[0]), 64'(model_rd[0]));
                n_rst = 1'b0;
                #1;
                check_reset_values();
                for (int k = 0; k < MB; k++) model_rd[k] = '0;
                @(negedge clk);
                n_rst = 1'b1;
                return;
            end
            @(negedge clk);
            if (i < rc * WC && (i % WC) == WC - 1) begin
                model_rd[i / WC] = ref_grey(rdata_tab[i / WC]);
            end
        end
        start = 1'b0;
        chk("fin_done", 64'(done), 64'd1);
        chk("fin_err", 64'(err), 64'(err_exp));
        chk("fin_busy", 64'(busy), 64'd1);
        chk("fin_re", 64'(sram_re), 64'd0);
        chk("fin_we", 64'(sram_we), 64'd0);
        @(negedge clk);
        chk("idle_done", 64'(done), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
        for (int k = 0; k < MB; k++) begin
            chk("rd_pixels", 64'(rd_pixels[k]), 64'(model_rd[k]));
        end
    endtask

    initial begin
        n_rst      = 1'b0;
        start      = 1'b0;
        rd_base    = '0;
        wr_base    = '0;
        rd_count   = '0;
        wr_count   = '0;
        wr_pixels  = '0;
        sram_rdata = '0;
        for (int k = 0; k < MB; k++) begin
            model_rd[k]  = '0;
            rdata_tab[k] = '0;
        end
        #12;
        check_reset_values();
        @(negedge clk);
        n_rst = 1'b1;

        // Grey read with the documented colour values.
        rdata_tab[0] = 24'hFFFFFF;
        rdata_tab[1] = 24'h102030;
        rdata_tab[2] = 24'h000000;
        run_txn(16'h0100, 16'h0000, 3, 0, -1, -1);
        chk("grey0", 64'(rd_pixels[0]), 64'hFB);
        chk("grey1", 64'(rd_pixels[1]), 64'h1F);
        chk("grey2", 64'(rd_pixels[2]), 64'h00);

        // Write only.
        wr_pixels[0] = 8'h55;
        wr_pixels[1] = 8'hA0;
        run_txn(16'h0000, 16'h0200, 0, 2, -1, -1);

        // Combined with read address wrap.
        rdata_tab[0] = 24'h123456;
        rdata_tab[1] = 24'hABCDEF;
        wr_pixels[0] = 8'h3C;
        run_txn(16'hFFFF, 16'h0300, 2, 1, -1, -1);

        // Error, then a valid start clears err.
        run_txn(16'h0000, 16'h0000, 21, 0, -1, -1);
        run_txn(16'h0000, 16'h0000, 0, 0, -1, -1);
        run_txn(16'h0040, 16'h0050, 1, 1, -1, -1);

        // Start while busy is ignored.
        run_txn(16'h0400, 16'h0500, 2, 2, 5, -1);

        // Reset in the middle of READ, after the first capture.
        rdata_tab[0] = 24'hFFFFFF;
        rdata_tab[1] = 24'h808080;
        rdata_tab[2] = 24'h010203;
        run_txn(16'h0600, 16'h0000, 3, 0, -1, 12);

        // Randomized transactions.
        for (int t = 0; t < 8; t++) begin
            for (int k = 0; k < MB; k++) begin
                rdata_tab[k] = 24'($urandom);
                wr_pixels[k] = 8'($urandom);
            end
            run_txn(16'($urandom), 16'($urandom),
                    int'($urandom_range(0, MB)), int'($urandom_range(0, MB)), -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
